// File: rtl/tty_display_if.sv
// Bundle between the IO block and the TTY display controller: character handshake,
// frame-buffer write port and the cursor/scroll status the video side needs.
interface tty_display_if #(
    parameter int ADDR_W = 11
);
    logic [6:0]        TTY_data;
    logic              TTY_en;
    logic              TTY_clear;
    logic              TTY_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [6:0]        fb_data;
    logic [5:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic [4:0]        top_row;

    modport master (
        output TTY_data, TTY_en, TTY_clear,
        input  TTY_ready, fb_we, fb_addr, fb_data, cursor_col, cursor_row, top_row
    );

    modport slave (
        input  TTY_data, TTY_en, TTY_clear,
        output TTY_ready, fb_we, fb_addr, fb_data, cursor_col, cursor_row, top_row
    );
endinterface

// File: rtl/tty_display_ctrl.sv
// TTY responder: turns ASCII strobes into frame-buffer writes, tracks the cursor and scrolls by
// rotating top_row. Backspace handling is compiled in when TTY_BACKSPACE_EN is defined.
module tty_display_ctrl #(
    parameter int         COLS   = 40,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 11,
    parameter logic [6:0] BLANK  = 7'h20
) (
    input logic          clk,
    input logic          reset,
    tty_display_if.slave bus
);
    localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [5:0]        ROWS_W6   = 6'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_SCRL = ADDR_W'(COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SCROLL, S_CLEAR} state_t;

    state_t            state, state_n;
    logic [5:0]        col, col_n;
    logic [4:0]        row, row_n;
    logic [4:0]        top, top_n;
    logic [ADDR_W-1:0] sweep, sweep_n;
    logic [6:0]        char_q;

    logic              we;
    logic [5:0]        wr_col;
    logic [4:0]        wr_row;
    logic [6:0]        wr_data;
    logic [5:0]        row_sum;
    logic [5:0]        phys_row;
    logic [4:0]        top_inc;
    logic              is_print;
    logic              is_lf;
    logic              is_cr;
`ifdef TTY_BACKSPACE_EN
    logic              is_bs;
    assign is_bs    = (char_q == 7'h08);
`endif

    assign is_print = (char_q >= 7'h20) && (char_q != 7'h7F);
    assign is_lf    = (char_q == 7'h0A);
    assign is_cr    = (char_q == 7'h0D);
    assign top_inc  = (top == LAST_ROW) ? 5'd0 : top + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_CLEAR;
            col    <= '0;
            row    <= '0;
            top    <= '0;
            sweep  <= '0;
            char_q <= BLANK;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            top   <= top_n;
            sweep <= sweep_n;
            if (state == S_IDLE && bus.TTY_en)
                char_q <= bus.TTY_data;
        end
    end

    // The write position defaults to the cursor; SCROLL and backspace redirect it.
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        top_n   = top;
        sweep_n = sweep;
        we      = 1'b0;
        wr_col  = col;
        wr_row  = row;
        wr_data = BLANK;

        case (state)
            S_IDLE: begin
                if (bus.TTY_en)
                    state_n = S_WRITE;
            end
            S_WRITE: begin
                state_n = S_IDLE;
                if (is_print) begin
                    we      = 1'b1;
                    wr_data = char_q;
                    if (col == LAST_COL) begin
                        col_n = '0;
                        if (row == LAST_ROW) begin
                            top_n   = top_inc;
                            sweep_n = '0;
                            state_n = S_SCROLL;
                        end else begin
                            row_n = row + 5'd1;
                        end
                    end else begin
                        col_n = col + 6'd1;
                    end
                end else if (is_lf) begin
                    col_n = '0;
                    if (row == LAST_ROW) begin
                        top_n   = top_inc;
                        sweep_n = '0;
                        state_n = S_SCROLL;
                    end else begin
                        row_n = row + 5'd1;
                    end
                end else if (is_cr) begin
                    col_n = '0;
                end
`ifdef TTY_BACKSPACE_EN
                else if (is_bs) begin
                    if (col != 6'd0) begin
                        col_n  = col - 6'd1;
                        wr_col = col - 6'd1;
                        we     = 1'b1;
                    end else if (row != 5'd0) begin
                        col_n  = LAST_COL;
                        row_n  = row - 5'd1;
                        wr_col = LAST_COL;
                        wr_row = row - 5'd1;
                        we     = 1'b1;
                    end
                end
`endif
            end
            S_SCROLL: begin
                // top_row already advanced, so the cursor row is the new bottom physical row.
                we     = 1'b1;
                wr_col = 6'(sweep);
                if (sweep == LAST_SCRL) begin
                    sweep_n = '0;
                    state_n = S_IDLE;
                end else begin
                    sweep_n = sweep + ADDR_W'(1);
                end
            end
            S_CLEAR: begin
                we = 1'b1;
                if (sweep == LAST_CELL) begin
                    sweep_n = '0;
                    state_n = S_IDLE;
                end else begin
                    sweep_n = sweep + ADDR_W'(1);
                end
            end
            default: state_n = S_CLEAR;
        endcase

        if (bus.TTY_clear) begin
            state_n = S_CLEAR;
            col_n   = '0;
            row_n   = '0;
            top_n   = '0;
            sweep_n = '0;
        end
    end

    // Modular row add by conditional subtract keeps fb_addr inside the COLS*ROWS window.
    always_comb begin
        row_sum  = {1'b0, top} + {1'b0, wr_row};
        phys_row = (row_sum >= ROWS_W6) ? row_sum - ROWS_W6 : row_sum;
    end

    assign bus.fb_addr    = (state == S_CLEAR) ? sweep
                          : ADDR_W'(int'(phys_row) * COLS + int'(wr_col));
    assign bus.fb_we      = we & ~reset;
    assign bus.fb_data    = wr_data;
    assign bus.TTY_ready  = (state == S_IDLE) & ~reset;
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;
    assign bus.top_row    = top;
endmodule

// File: tb/tb_tty_display_ctrl.sv
// Bench for tty_display_ctrl: directed vector table, multi-cycle corner sequences and a random
// character stream checked against a linear-cursor / shadow frame-buffer model.
module tb_tty_display_ctrl;
    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int BUDGET = 3000;
    localparam int BLANK  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tty_display_if #(.ADDR_W(11)) bus ();

    tty_display_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(11), .BLANK(7'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ch;
        int         n_wr;
        int         addr;
        int         data;
        int         col;
        int         row;
        int         top;
    } vec_t;

    vec_t vecs [13];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   wq_addr[$];
    int   wq_data[$];
    int   exp_addr[$];
    int   exp_data[$];
    int   dut_mem [CELLS];
    int   ref_mem [CELLS];
    int   m_col, m_row, m_top, m_busy;

    // Passive monitor: records every frame-buffer write and counts not-ready cycles.
    always @(negedge clk) begin
        if (bus.fb_we === 1'b1) begin
            wq_addr.push_back(int'(bus.fb_addr));
            wq_data.push_back(int'(bus.fb_data));
            if (int'(bus.fb_addr) < CELLS)
                dut_mem[int'(bus.fb_addr)] = int'(bus.fb_data);
        end
        if (bus.TTY_ready !== 1'b1)
            busy_cnt++;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wq_addr.delete();
        wq_data.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.TTY_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (bus.TTY_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got 0 expected 1 within %0d cycles", BUDGET);
        end
    endtask

    // Send one character; optionally hold TTY_en a second cycle, which must be dropped.
    task automatic applyStimulus(input logic [6:0] c, input bit spurious);
        wait_ready();
        clear_obs();
        bus.TTY_data = c;
        bus.TTY_en   = 1'b1;
        step();
        if (spurious) begin
            bus.TTY_data = 7'($urandom);
            step();
        end
        bus.TTY_en = 1'b0;
        wait_ready();
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_addr.push_back(addr);
        exp_data.push_back(data);
        ref_mem[addr] = data;
    endtask

    function automatic int phys_addr(input int r, input int c);
        return ((m_top + r) % ROWS) * COLS + c;
    endfunction

    task automatic model_scroll();
        m_top  = (m_top + 1) % ROWS;
        m_row  = ROWS - 1;
        m_col  = 0;
        m_busy += COLS;
        for (int i = 0; i < COLS; i++)
            push_exp(phys_addr(ROWS - 1, i), BLANK);
    endtask

    // Cursor is treated as a linear position row*COLS+col on a scrolling page.
    task automatic model_char(input logic [6:0] c);
        int pos;
        exp_addr.delete();
        exp_data.delete();
        m_busy = 1;
        pos = m_row * COLS + m_col;
        if (c >= 7'h20 && c != 7'h7F) begin
            push_exp(phys_addr(m_row, m_col), int'(c));
            pos++;
            if (pos == CELLS) begin
                model_scroll();
            end else begin
                m_row = pos / COLS;
                m_col = pos % COLS;
            end
        end else if (c == 7'h0A) begin
            m_col = 0;
            if (m_row == ROWS - 1) model_scroll();
            else m_row++;
        end else if (c == 7'h0D) begin
            m_col = 0;
        end
`ifdef TTY_BACKSPACE_EN
        else if (c == 7'h08 && pos > 0) begin
            pos--;
            m_row = pos / COLS;
            m_col = pos % COLS;
            push_exp(phys_addr(m_row, m_col), BLANK);
        end
`endif
    endtask

    task automatic model_clear();
        m_col = 0;
        m_row = 0;
        m_top = 0;
        for (int i = 0; i < CELLS; i++)
            ref_mem[i] = BLANK;
    endtask

    task automatic check_cursor(input string tag, input int c, input int r, input int t);
        checkOutput({tag, "_col"}, int'(bus.cursor_col), c);
        checkOutput({tag, "_row"}, int'(bus.cursor_row), r);
        checkOutput({tag, "_top"}, int'(bus.top_row), t);
    endtask

    task automatic check_model(input string tag);
        int diffs = 0;
        int n;
        n = (wq_addr.size() < exp_addr.size()) ? wq_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++)
            if (wq_addr[i] != exp_addr[i] || wq_data[i] != exp_data[i])
                diffs++;
        checkOutput({tag, "_wr_count"}, wq_addr.size(), exp_addr.size());
        checkOutput({tag, "_wr_content"}, diffs, 0);
        checkOutput({tag, "_busy"}, busy_cnt, m_busy);
        check_cursor(tag, m_col, m_row, m_top);
    endtask

    task automatic check_sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] != BLANK)
                bad++;
        checkOutput({tag, "_sweep_count"}, wq_addr.size(), CELLS);
        checkOutput({tag, "_sweep_content"}, bad, 0);
        checkOutput({tag, "_sweep_busy"}, busy_cnt, CELLS);
        check_cursor(tag, 0, 0, 0);
    endtask

    // Clear from IDLE; with_en also raises TTY_en, which clear must override.
    task automatic do_clear(input bit with_en);
        wait_ready();
        clear_obs();
        bus.TTY_clear = 1'b1;
        bus.TTY_en    = with_en;
        bus.TTY_data  = 7'h51;
        step();
        bus.TTY_clear = 1'b0;
        bus.TTY_en    = 1'b0;
        wait_ready();
        check_sweep(with_en ? "clear_en" : "clear");
        model_clear();
    endtask

    initial begin
        int bad;
        logic [6:0] c;

        vecs[0]  = '{7'h08, 0,  -1, 0,     0, 0, 0};
        vecs[1]  = '{7'h41, 1,   0, 'h41,  1, 0, 0};
        vecs[2]  = '{7'h0D, 0,  -1, 0,     0, 0, 0};
        vecs[3]  = '{7'h0A, 0,  -1, 0,     0, 1, 0};
        vecs[4]  = '{7'h42, 1,  40, 'h42,  1, 1, 0};
        vecs[5]  = '{7'h07, 0,  -1, 0,     1, 1, 0};
        vecs[6]  = '{7'h7F, 0,  -1, 0,     1, 1, 0};
        vecs[7]  = '{7'h0A, 0,  -1, 0,     0, 2, 0};
        vecs[8]  = '{7'h0A, 0,  -1, 0,     0, 3, 0};
`ifdef TTY_BACKSPACE_EN
        vecs[9]  = '{7'h08, 1, 119, 'h20, 39, 2, 0};
        vecs[10] = '{7'h7E, 1, 119, 'h7E,  0, 3, 0};
        vecs[11] = '{7'h20, 1, 120, 'h20,  1, 3, 0};
        vecs[12] = '{7'h08, 1, 120, 'h20,  0, 3, 0};
`else
        vecs[9]  = '{7'h08, 0,  -1, 0,     0, 3, 0};
        vecs[10] = '{7'h7E, 1, 120, 'h7E,  1, 3, 0};
        vecs[11] = '{7'h20, 1, 121, 'h20,  2, 3, 0};
        vecs[12] = '{7'h08, 0,  -1, 0,     2, 3, 0};
`endif

        bus.TTY_data  = 7'h00;
        bus.TTY_en    = 1'b0;
        bus.TTY_clear = 1'b0;
        reset         = 1'b1;
        step();
        step();
        checkOutput("rst_fb_we", int'(bus.fb_we), 0);
        checkOutput("rst_ready", int'(bus.TTY_ready), 0);
        check_cursor("rst", 0, 0, 0);
        reset = 1'b0;
        clear_obs();
        wait_ready();
        check_sweep("reset");
        model_clear();

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ch, 1'b0);
            model_char(vecs[i].ch);
            checkOutput($sformatf("vec%0d_wr_count", i), wq_addr.size(), vecs[i].n_wr);
            if (vecs[i].n_wr > 0) begin
                checkOutput($sformatf("vec%0d_addr", i), (wq_addr.size() > 0) ? wq_addr[0] : -1, vecs[i].addr);
                checkOutput($sformatf("vec%0d_data", i), (wq_data.size() > 0) ? wq_data[0] : -1, vecs[i].data);
            end
            checkOutput($sformatf("vec%0d_busy", i), busy_cnt, 1);
            check_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row, vecs[i].top);
        end

        $display("[TB] row fill, line feed and bottom-row scroll");
        do_clear(1'b1);
        for (int i = 0; i < COLS; i++) begin
            applyStimulus(7'h30, 1'b0);
            model_char(7'h30);
            check_model("fill");
        end
        bad = 0;
        for (int i = 0; i < COLS; i++)
            if (dut_mem[i] != 'h30) bad++;
        checkOutput("row0_filled", bad, 0);
        check_cursor("after_fill", 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7'h0A, 1'b0);
            model_char(7'h0A);
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(7'h61 + 7'(i), 1'b0);
            model_char(7'h61 + 7'(i));
        end
        check_cursor("at_7_5", 7, 5, 0);
        applyStimulus(7'h0A, 1'b0);
        model_char(7'h0A);
        checkOutput("lf_no_write", wq_addr.size(), 0);
        check_cursor("lf_7_5", 0, 6, 0);
        for (int i = 0; i < 23; i++) begin
            applyStimulus(7'h0A, 1'b0);
            model_char(7'h0A);
            check_model("lf_down");
        end
        for (int i = 0; i < COLS - 1; i++) begin
            applyStimulus(7'h2E, 1'b0);
            model_char(7'h2E);
        end
        check_cursor("at_39_29", 39, 29, 0);
        applyStimulus(7'h5A, 1'b0);
        model_char(7'h5A);
        check_model("wrap_scroll");
        checkOutput("scroll_first_addr", (wq_addr.size() > 0) ? wq_addr[0] : -1, 1199);
        checkOutput("scroll_first_data", (wq_data.size() > 0) ? wq_data[0] : -1, 'h5A);
        checkOutput("scroll_blank_addr0", (wq_addr.size() > 1) ? wq_addr[1] : -1, 0);
        checkOutput("scroll_blank_addr39", (wq_addr.size() > 40) ? wq_addr[40] : -1, 39);
        checkOutput("scroll_busy", busy_cnt, 41);
        check_cursor("after_scroll", 0, 29, 1);
        applyStimulus(7'h42, 1'b0);
        model_char(7'h42);
        check_model("post_scroll");
        checkOutput("post_scroll_addr", (wq_addr.size() > 0) ? wq_addr[0] : -1, 0);

        $display("[TB] clear with simultaneous strobe during scroll");
        wait_ready();
        bus.TTY_data = 7'h0A;
        bus.TTY_en   = 1'b1;
        step();
        bus.TTY_en = 1'b0;
        step();
        repeat (5) step();
        checkOutput("in_scroll_ready", int'(bus.TTY_ready), 0);
        bus.TTY_clear = 1'b1;
        bus.TTY_en    = 1'b1;
        bus.TTY_data  = 7'h51;
        step();
        bus.TTY_clear = 1'b0;
        bus.TTY_en    = 1'b0;
        clear_obs();
        wait_ready();
        check_sweep("clear_in_scroll");
        model_clear();

        $display("[TB] reset in the middle of a clear sweep");
        bus.TTY_clear = 1'b1;
        step();
        bus.TTY_clear = 1'b0;
        repeat (500) step();
        reset = 1'b1;
        step();
        checkOutput("midsweep_rst_we", int'(bus.fb_we), 0);
        reset = 1'b0;
        clear_obs();
        wait_ready();
        check_sweep("reset_midsweep");
        model_clear();

        $display("[TB] randomized character stream");
        do_clear(1'b0);
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 68)      c = 7'($urandom_range(32, 126));
            else if (r < 83) c = 7'h0A;
            else if (r < 88) c = 7'h0D;
            else if (r < 93) c = 7'h08;
            else begin
                c = 7'($urandom_range(0, 31));
                if (c == 7'h08 || c == 7'h0A || c == 7'h0D) c = 7'h7F;
            end
            repeat ($urandom_range(0, 2)) step();
            applyStimulus(c, $urandom_range(0, 3) == 0);
            model_char(c);
            check_model($sformatf("rand%0d", n));
        end
        bad = 0;
        for (int i = 0; i < CELLS; i++)
            if (dut_mem[i] != ref_mem[i]) bad++;
        checkOutput("fb_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
